// File: rtl/quad_trackball.sv
// quad_trackball: N-axis trackball/spinner emulator.
// Signed motion deltas are collected into a per-axis saturating step backlog.
// The backlog is drained one Gray-coded quadrature step at a time. The step
// period shortens as the backlog grows.
module quad_trackball #(
  parameter int NUM_AXES     = 2,
  parameter int DELTA_W      = 9,
  parameter int ACC_W        = 12,
  parameter int PERIOD_W     = 16,
  parameter int BASE_PERIOD  = 3000,
  parameter int PERIOD_SHIFT = 4,
  parameter int IDLE_CLEAR   = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         mouse_strobe,
  input  logic [NUM_AXES*DELTA_W-1:0]  mouse_delta,
  input  logic [1:0]                   speed,
  input  logic [NUM_AXES-1:0]          flip,
  input  logic                         clear,
  output logic [NUM_AXES-1:0]          quad_a,
  output logic [NUM_AXES-1:0]          quad_b,
  output logic [NUM_AXES-1:0]          step,
  output logic [NUM_AXES-1:0]          busy
);

  // Wide enough for the largest backlog plus a x16-scaled delta without overflow.
  localparam int SUM_W  = ACC_W + DELTA_W + 6;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(-((2 ** (ACC_W - 1)) - 1));
  localparam int IDLE_W = (IDLE_CLEAR > 1) ? $clog2(IDLE_CLEAR + 1) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic       strobe_prev_reg;
  logic       primed_reg;
  logic       strobe_event;
  logic [2:0] shift_amt;

  // Track the toggle strobe; the first clock after reset only primes the history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_prev_reg <= 1'b0;
      primed_reg      <= 1'b0;
    end else begin
      strobe_prev_reg <= mouse_strobe;
      primed_reg      <= 1'b1;
    end
  end

  assign strobe_event = primed_reg && (mouse_strobe != strobe_prev_reg);

  // Decode speed into a left-shift amount (x1, x2, x4, x16).
  always_comb begin
    shift_amt = 3'd0;
    case (speed)
      2'd0:    shift_amt = 3'd0;
      2'd1:    shift_amt = 3'd1;
      2'd2:    shift_amt = 3'd2;
      default: shift_amt = 3'd4;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
      state_t                   state_reg;
      logic signed [ACC_W-1:0]  acc_reg;
      logic signed [ACC_W-1:0]  acc_next;
      logic [PERIOD_W-1:0]      count_reg;
      logic [PERIOD_W-1:0]      period_reg;
      logic [PERIOD_W-1:0]      period_next;
      logic                     a_reg;
      logic                     b_reg;
      logic                     step_reg;
      logic                     busy_reg;
      logic signed [SUM_W-1:0]  delta_ext;
      logic signed [SUM_W-1:0]  scaled;
      logic signed [SUM_W-1:0]  acc_ext;
      logic signed [SUM_W-1:0]  adjust;
      logic signed [SUM_W-1:0]  sum;
      logic [ACC_W-1:0]         acc_abs;
      logic [7:0]               mag8;
      logic                     step_fire;
      logic                     fwd;
      logic                     idle_expire;

      assign delta_ext = {{(SUM_W-DELTA_W){mouse_delta[gi*DELTA_W+DELTA_W-1]}},
                          mouse_delta[gi*DELTA_W +: DELTA_W]};
      assign scaled    = delta_ext <<< shift_amt;
      assign acc_ext   = {{(SUM_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg};

      // A step is due once the counter has covered the period; clearing wins.
      assign step_fire = (state_reg == S_RUN) && (acc_reg != '0) &&
                         (count_reg >= period_reg) && !clear && !idle_expire;
      // Step toward zero: a positive backlog moves forward unless the axis is flipped.
      assign fwd       = (~acc_reg[ACC_W-1]) ^ flip[gi];
      assign adjust    = !step_fire ? '0 :
                         (acc_reg[ACC_W-1] ? {SUM_W{1'b1}} : SUM_W'(1));
      assign sum       = acc_ext + (strobe_event ? scaled : '0) - adjust;

      // Saturate the new backlog; clear or idle timeout discards it.
      always_comb begin
        acc_next = sum[ACC_W-1:0];
        if (clear || idle_expire) begin
          acc_next = '0;
        end else if (sum > ACC_MAX) begin
          acc_next = ACC_MAX[ACC_W-1:0];
        end else if (sum < ACC_MIN) begin
          acc_next = ACC_MIN[ACC_W-1:0];
        end
      end

      // Period shrinks with backlog magnitude (clamped to 255).
      assign acc_abs     = acc_reg[ACC_W-1] ? (~acc_reg + ACC_W'(1)) : acc_reg;
      assign mag8        = (acc_abs > ACC_W'(255)) ? 8'hFF : acc_abs[7:0];
      assign period_next = PERIOD_W'(BASE_PERIOD) +
                           (PERIOD_W'(8'hFF - mag8) << PERIOD_SHIFT);

      if (IDLE_CLEAR != 0) begin : g_idle
        localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_CLEAR);
        logic [IDLE_W-1:0] idle_cnt_reg;

        // Count clocks since the last strobe event, holding at the limit.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            idle_cnt_reg <= '0;
          end else if (strobe_event || clear) begin
            idle_cnt_reg <= '0;
          end else if (idle_cnt_reg != IDLE_LIMIT) begin
            idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
          end
        end

        assign idle_expire = (idle_cnt_reg == IDLE_LIMIT) && !strobe_event;
      end else begin : g_no_idle
        assign idle_expire = 1'b0;
      end

      // Step FSM with backlog, period, quadrature phase and status registers.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_reg  <= S_IDLE;
          acc_reg    <= '0;
          count_reg  <= '0;
          period_reg <= '0;
          a_reg      <= 1'b0;
          b_reg      <= 1'b0;
          step_reg   <= 1'b0;
          busy_reg   <= 1'b0;
        end else begin
          acc_reg    <= acc_next;
          busy_reg   <= (acc_next != '0);
          period_reg <= period_next;
          step_reg   <= step_fire;
          if (step_fire) begin
            if (fwd) begin
              a_reg <= b_reg;
              b_reg <= ~a_reg;
            end else begin
              a_reg <= ~b_reg;
              b_reg <= a_reg;
            end
          end
          if (clear || idle_expire) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
          end else begin
            case (state_reg)
              S_IDLE: begin
                count_reg <= '0;
                if (acc_reg != '0) state_reg <= S_RUN;
              end
              default: begin
                if (acc_reg == '0) begin
                  state_reg <= S_IDLE;
                  count_reg <= '0;
                end else if (step_fire) begin
                  count_reg <= '0;
                end else if (count_reg != {PERIOD_W{1'b1}}) begin
                  count_reg <= count_reg + PERIOD_W'(1);
                end
              end
            endcase
          end
        end
      end

      assign quad_a[gi] = a_reg;
      assign quad_b[gi] = b_reg;
      assign step[gi]   = step_reg;
      assign busy[gi]   = busy_reg;
    end
  endgenerate

endmodule

// File: doc/quad_trackball.md
Name: quad_trackball

Overview:
- Parametrised N-axis trackball/spinner emulator that produces true two-phase quadrature (A/B) per axis, replacing the clk/dir style emulation.
- Signed motion deltas (from a mouse packet or another motion source) go into a per-axis step backlog accumulator.
- The backlog drains one quadrature step at a time, at a rate that rises with backlog size.
- Sits between the HPS input interface and the game core's trackball input decoder.

Parameters:
- NUM_AXES, 2, number of independent axes.
- DELTA_W, 9, width of each signed input delta (two's complement).
- ACC_W, 12, width of each signed backlog accumulator.
- PERIOD_W, 16, width of the step-period counter.
- BASE_PERIOD, 3000, minimum clocks between steps, used at maximum backlog.
- PERIOD_SHIFT, 4, left shift applied to (255 - magnitude) when computing the period.
- IDLE_CLEAR, 0, if non-zero: clocks without a strobe after which the backlog is discarded.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- mouse_strobe  in  1  toggle; each level change delivers one set of deltas.
- mouse_delta  in  NUM_AXES*DELTA_W  signed deltas; axis i occupies bits [i*DELTA_W +: DELTA_W].
- speed  in  2  delta scaling: 0=x1, 1=x2, 2=x4, 3=x16.
- flip  in  NUM_AXES  per-axis direction inversion.
- clear  in  1  synchronous; zeroes all backlogs.
- quad_a  out  NUM_AXES  phase A per axis.
- quad_b  out  NUM_AXES  phase B per axis.
- step  out  NUM_AXES  one-cycle pulse for each emitted step.
- busy  out  NUM_AXES  backlog non-zero.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - quad_a/quad_b=0, step=0, busy=0.
  - All accumulators, period counters and idle counters = 0.
  - Strobe tracking is unprimed.
- Strobe detection:
  - First clock after reset only samples mouse_strobe. This is the priming cycle, and no event is generated.
  - After priming, a difference between mouse_strobe and its registered value is an event in that cycle.
- Accumulate (per axis, on an event):
  - Sign-extend the delta, shift by speed, add to the accumulator.
  - Saturate to ±(2^(ACC_W-1)-1); no wrap.
  - The new value is visible the next cycle.
- Period calculation:
  - mag = min(|acc|, 255).
  - period = BASE_PERIOD + ((255-mag) << PERIOD_SHIFT), computed in PERIOD_W bits and registered, so it lags acc by 1 cycle.
- Per-axis step FSM, states IDLE and RUN:
  - IDLE: counter=0. If acc≠0, go to RUN.
  - RUN: counter increments. When counter ≥ period, emit a step, set counter=0, and move acc one toward zero.
  - When acc reaches 0, return to IDLE and clear the counter.
  - Minimum step spacing is BASE_PERIOD+1 clocks.
- Step direction and phase encoding:
  - Direction is the sign of acc at the step cycle, XOR flip[i].
  - Positive advances Gray phase 00→01→11→10→00 ({A,B}); negative retreats.
  - Exactly one of A/B changes per step.
  - step pulses in the same cycle the phase changes.
- Simultaneous event and step on the same axis: the result is acc + scaled_delta - sign(acc), saturated afterwards.
- Sign reversal: an opposite-sign delta cancels backlog first. The direction follows the new sign from the next step on; no phase glitch.
- clear:
  - Has priority over events and steps.
  - Zeroes acc and counters, forces IDLE.
  - Holds quad phase (no phase jump).
- IDLE_CLEAR≠0: per-axis idle counter resets on every event. When it reaches IDLE_CLEAR, acc=0 (same effect as clear for that axis).
- busy[i] = (acc≠0), registered.
- Axes are fully independent apart from the shared strobe, speed and clear.

Test Plan:
- Reset release with mouse_strobe=1 held → no event, acc=0, quad outputs stay 00, busy=0.
- Axis0 delta=+3, speed=0, toggle strobe →
  - exactly 3 steps, phases 01,11,10;
  - step spacing = 3000+((255-mag)<<4)+1 clocks at the magnitude current at each step;
  - busy falls after the 3rd step.
- Axis1 delta=-2 with flip[1]=1 → 2 forward steps (01,11); axis0 unchanged.
- speed=3, delta=+200 repeated 2 times (ACC_W=12) → acc saturates at 2047, no wrap; first period = 3000.
- acc=+10 draining, deliver delta=-15 → acc goes to about -5 (±1 for in-flight step). Subsequent steps retreat the phase; exactly one bit changes per step throughout.
- clear asserted mid-RUN → acc=0 next cycle, no further steps, quad phase retained. Async reset_n pulse mid-RUN → all outputs 0 immediately.
